mo_line_buffer: RTL and testbench
=================================

Name: mo_line_buffer

Overview:
- Double-buffered (ping-pong) motion-object line buffer directly downstream of the MO horizontal address counters.
- Buffer A is indexed by addr1; buffer B is indexed by addr2. Each buffer is 256 x 4 bits.
- During a scanline, one buffer collects MO pixels from the picture shift register. The other buffer is read out to the video mixer and erased behind the read.
- A line-parity select swaps the roles of the two buffers every line.

Parameters:
- PIX_W, 4, width of an MO pixel (colour index); value 0 is transparent.
- DEPTH_LOG2, 8, address width; must match the counter width (256 locations).
- INIT_CLEAR, 1, 1 = run a full-buffer erase sweep after reset; 0 = no sweep.

Ports:
- clk  in  1  master clock.
- reset  in  1  asynchronous, active-high reset.
- ce5  in  1  pixel clock enable; all functional updates occur on clk edges with ce5=1.
- addr1  in  8  address counter for buffer A.
- addr2  in  8  address counter for buffer B.
- sel  in  1  0: A writes, B reads/clears. 1: B writes, A reads/clears.
- wr_en  in  1  MO pixel data valid for the write buffer.
- pix_in  in  PIX_W  MO pixel to write.
- rd_en  in  1  readout window active (visible line portion).
- mo_pix  out  PIX_W  registered MO pixel to the mixer.
- busy  out  1  init sweep in progress.

Behaviour:
- Reset (asynchronous):
  - mo_pix=0.
  - Internal sweep counter=0.
  - busy=1 if INIT_CLEAR=1, else busy=0.
  - RAM contents are not reset directly.
- Init sweep (busy=1):
  - Runs on every clk cycle, independent of ce5.
  - Writes 0 to location cnt in both buffers, then increments cnt.
  - After location 255 is written, busy falls on the next edge. The sweep takes exactly 256 clk cycles after reset deasserts.
  - While busy=1: writes and reads are ignored and mo_pix is held at 0.
  - If reset is reasserted mid-sweep, the sweep restarts from 0.
- Write path (busy=0, ce5=1, wr_en=1):
  - The write buffer is A when sel=0, B when sel=1. It uses its own address (addr1 for A, addr2 for B).
  - The location is written with pix_in only if pix_in != 0, so transparent pixels never overwrite.
  - A nonzero pix_in overwrites unconditionally: the last object drawn wins.
  - Nothing is written when wr_en=0.
- Read/clear path (busy=0, ce5=1, rd_en=1):
  - The read buffer is the one not selected for write.
  - On the ce5 edge, mo_pix <= mem[read buffer][read addr] using the pre-edge contents (read-first).
  - On the same edge, that location is written to 0.
  - Latency: mo_pix shows the pixel for the address that was held during the preceding ce5 period.
- rd_en=0 (busy=0, ce5=1): mo_pix <= 0 and no clear occurs.
- ce5=0: mo_pix and the RAMs hold.
- Simultaneous events:
  - Write and read always target different buffers, so there is no port conflict.
  - addr1==addr2 has no special meaning.
- sel timing:
  - sel is sampled on each ce5 edge. A toggle takes effect on the first ce5 edge at which the new value is present.
  - No sweep or flush is triggered by a toggle.
  - A location read and cleared under the old sel keeps the value 0.
- Address wrap: addresses wrap modulo 256 inside the counters. The buffer indexes them directly with no bounds logic.
- RAM implementation:
  - Each buffer is inferable as a single-port read-first block RAM, with the sweep muxed onto the port.
  - Alternatively, the two buffers may be one true dual-port RAM with a bank bit.

Test Plan:
- Reset with INIT_CLEAR=1: assert reset, release -> busy=1 for exactly 256 clk cycles, then 0. Readback of all 512 locations -> 0. mo_pix=0 throughout.
- Write/read: sel=0, write pix_in=5 at addr1=0x40, 6 at 0x41. Set sel=1 and step addr1 through 0x40,0x41 with rd_en=1 -> mo_pix=5 then 6, one ce5 behind each address. Second pass over the same addresses -> 0 (cleared).
- Transparency: sel=0, write 9 at addr1=0x10, then 0 at 0x10, then 3 at 0x11 followed by 7 at 0x11 -> readout gives 9 at 0x10 and 7 at 0x11.
- rd_en gating: sel=1, buffer A holds 4 at 0x20, read with rd_en=0 -> mo_pix=0. Re-read with rd_en=1 -> mo_pix=4, then 0 on the next pass.
- Independence: sel=0, write 2 to addr1=0x80 while reading B at addr2=0x80 that holds 0xC -> mo_pix=0xC. B@0x80 becomes 0 and A@0x80 becomes 2. Stall with ce5=0 for 10 clocks -> no state change.
- Reset mid-operation: with data written in A, assert reset during a readout -> mo_pix=0 immediately (asynchronous). New sweep of 256 cycles -> A reads all zero.

Source files
------------

// File: rtl/mo_line_buffer.sv
// Ping-pong motion-object line buffer: one 256-entry bank collects MO pixels
// while the other is read out to the mixer and erased behind the read.
module mo_line_buffer #(
  parameter int PIX_W      = 4,
  parameter int DEPTH_LOG2 = 8,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce5,
  input  logic [DEPTH_LOG2-1:0] addr1,
  input  logic [DEPTH_LOG2-1:0] addr2,
  input  logic                  sel,
  input  logic                  wr_en,
  input  logic [PIX_W-1:0]      pix_in,
  input  logic                  rd_en,
  output logic [PIX_W-1:0]      mo_pix,
  output logic                  busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {
    ST_SWEEP,
    ST_RUN
  } state_t;

  localparam state_t RESET_STATE = INIT_CLEAR ? ST_SWEEP : ST_RUN;

  logic [PIX_W-1:0] mem_a [0:DEPTH-1];
  logic [PIX_W-1:0] mem_b [0:DEPTH-1];

  state_t                state, state_next;
  logic [DEPTH_LOG2-1:0] cnt, cnt_next;

  logic                  we_a, we_b;
  logic [DEPTH_LOG2-1:0] waddr_a, waddr_b;
  logic [PIX_W-1:0]      din_a, din_b;
  logic [PIX_W-1:0]      rd_pix;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RESET_STATE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // The sweep owns both RAM ports; otherwise the bank selected by sel takes
  // opaque pixels and the other bank is zeroed at whatever it is reading.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    we_a       = 1'b0;
    we_b       = 1'b0;
    waddr_a    = addr1;
    waddr_b    = addr2;
    din_a      = pix_in;
    din_b      = pix_in;
    case (state)
      ST_SWEEP: begin
        we_a     = 1'b1;
        we_b     = 1'b1;
        waddr_a  = cnt;
        waddr_b  = cnt;
        din_a    = '0;
        din_b    = '0;
        cnt_next = cnt + DEPTH_LOG2'(1);
        if (&cnt) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (ce5) begin
          if (!sel) begin
            we_a  = wr_en && (pix_in != '0);
            we_b  = rd_en;
            din_b = '0;
          end else begin
            we_b  = wr_en && (pix_in != '0);
            we_a  = rd_en;
            din_a = '0;
          end
        end
      end
      default: state_next = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we_a) mem_a[waddr_a] <= din_a;
    if (we_b) mem_b[waddr_b] <= din_b;
  end

  assign rd_pix = sel ? mem_a[addr1] : mem_b[addr2];
  assign busy   = (state == ST_SWEEP);

  // Read-first: the value captured is the pre-edge content of the location
  // being cleared on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mo_pix <= '0;
    end else if (busy) begin
      mo_pix <= '0;
    end else if (ce5) begin
      mo_pix <= rd_en ? rd_pix : '0;
    end
  end

endmodule

// File: tb/tb_mo_line_buffer.sv
// Self-checking bench for mo_line_buffer: a per-edge behavioural model of the
// two banks is compared against the DUT on every falling clock edge.
module tb_mo_line_buffer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ce5 = 1'b0;
  logic [7:0] addr1 = '0;
  logic [7:0] addr2 = '0;
  logic       sel = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] pix_in = '0;
  logic       rd_en = 1'b0;
  logic [3:0] mo_pix;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [3:0] ma [256];
  logic [3:0] mb [256];
  logic [3:0] exp_mo = '0;
  logic       exp_busy = 1'b0;
  int         sweep_left = 0;
  logic       cmp_en = 1'b0;

  mo_line_buffer #(.PIX_W(4), .DEPTH_LOG2(8), .INIT_CLEAR(1'b1)) dut (
    .clk(clk), .reset(reset), .ce5(ce5), .addr1(addr1), .addr2(addr2),
    .sel(sel), .wr_en(wr_en), .pix_in(pix_in), .rd_en(rd_en),
    .mo_pix(mo_pix), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("mo_pix", {4'b0, mo_pix}, {4'b0, exp_mo});
      checkOutput("busy", {7'b0, busy}, {7'b0, exp_busy});
    end
  end

  // Drive one clock of inputs and advance the model by one rising edge.
  task automatic applyStimulus(input logic c, input logic [7:0] a1, input logic [7:0] a2,
                               input logic s, input logic we, input logic [3:0] px,
                               input logic re);
    ce5 = c; addr1 = a1; addr2 = a2; sel = s; wr_en = we; pix_in = px; rd_en = re;
    @(posedge clk);
    if (sweep_left > 0) begin
      sweep_left--;
      exp_mo = '0;
    end else if (c) begin
      if (re) begin
        if (s) begin exp_mo = ma[a1]; ma[a1] = '0; end
        else   begin exp_mo = mb[a2]; mb[a2] = '0; end
      end else begin
        exp_mo = '0;
      end
      if (we && px != 4'd0) begin
        if (s) mb[a2] = px;
        else   ma[a1] = px;
      end
    end
    exp_busy = (sweep_left > 0);
    #1;
  endtask

  task automatic doReset(input logic check_async);
    reset = 1'b1;
    #1;
    if (check_async) checkOutput("async_reset_mo", {4'b0, mo_pix}, 8'h00);
    for (int i = 0; i < 256; i++) begin ma[i] = '0; mb[i] = '0; end
    sweep_left = 256;
    exp_mo     = '0;
    exp_busy   = 1'b1;
    cmp_en     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic runSweep();
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
                    1'b1, 4'($urandom), 1'b1);
      if (i == 254) checkOutput("busy_at_255", {7'b0, busy}, 8'h01);
    end
    checkOutput("busy_at_256", {7'b0, busy}, 8'h00);
    checkOutput("mo_after_sweep", {4'b0, mo_pix}, 8'h00);
  endtask

  task automatic readOne(input logic s, input logic [7:0] a, input logic re,
                         input string name, input logic [3:0] expv);
    applyStimulus(1'b1, a, a, s, 1'b0, 4'd0, re);
    checkOutput(name, {4'b0, mo_pix}, {4'b0, expv});
  endtask

  initial begin
    logic cur_sel;
    repeat (2) @(posedge clk);
    #1;
    doReset(1'b0);
    runSweep();

    // Every location of both banks must read back as zero after the sweep.
    for (int i = 0; i < 256; i++) applyStimulus(1'b1, 8'(i), 8'h00, 1'b1, 1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 256; i++) applyStimulus(1'b1, 8'h00, 8'(i), 1'b0, 1'b0, 4'd0, 1'b1);

    applyStimulus(1'b1, 8'h40, 8'h00, 1'b0, 1'b1, 4'd5, 1'b0);
    applyStimulus(1'b1, 8'h41, 8'h00, 1'b0, 1'b1, 4'd6, 1'b0);
    readOne(1'b1, 8'h40, 1'b1, "rd_40", 4'd5);
    readOne(1'b1, 8'h41, 1'b1, "rd_41", 4'd6);
    readOne(1'b1, 8'h40, 1'b1, "rd_40_cleared", 4'd0);
    readOne(1'b1, 8'h41, 1'b1, "rd_41_cleared", 4'd0);

    applyStimulus(1'b1, 8'h10, 8'h00, 1'b0, 1'b1, 4'd9, 1'b0);
    applyStimulus(1'b1, 8'h10, 8'h00, 1'b0, 1'b1, 4'd0, 1'b0);
    applyStimulus(1'b1, 8'h11, 8'h00, 1'b0, 1'b1, 4'd3, 1'b0);
    applyStimulus(1'b1, 8'h11, 8'h00, 1'b0, 1'b1, 4'd7, 1'b0);
    readOne(1'b1, 8'h10, 1'b1, "transparent_10", 4'd9);
    readOne(1'b1, 8'h11, 1'b1, "lastwins_11", 4'd7);

    applyStimulus(1'b1, 8'h20, 8'h00, 1'b0, 1'b1, 4'd4, 1'b0);
    readOne(1'b1, 8'h20, 1'b0, "rden_off", 4'd0);
    readOne(1'b1, 8'h20, 1'b1, "rden_on", 4'd4);
    readOne(1'b1, 8'h20, 1'b1, "rden_cleared", 4'd0);

    applyStimulus(1'b1, 8'h00, 8'h80, 1'b1, 1'b1, 4'hC, 1'b0);
    applyStimulus(1'b1, 8'h80, 8'h80, 1'b0, 1'b1, 4'd2, 1'b1);
    checkOutput("indep_b80", {4'b0, mo_pix}, 8'h0C);
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1, 4'hF, 1'b1);
    checkOutput("stall_hold", {4'b0, mo_pix}, 8'h0C);
    readOne(1'b0, 8'h80, 1'b1, "b80_cleared", 4'd0);
    readOne(1'b1, 8'h80, 1'b1, "a80_written", 4'd2);

    // Random traffic on a narrow address window so locations are revisited.
    cur_sel = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) cur_sel = ~cur_sel;
      applyStimulus(($urandom_range(0, 9) < 7), 8'($urandom_range(0, 15)),
                    8'($urandom_range(0, 15)), cur_sel, 1'($urandom), 4'($urandom),
                    ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 1000; i++)
      applyStimulus(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
                    1'($urandom), 4'($urandom), 1'($urandom));

    applyStimulus(1'b1, 8'h05, 8'h00, 1'b0, 1'b1, 4'hA, 1'b0);
    applyStimulus(1'b1, 8'h06, 8'h00, 1'b0, 1'b1, 4'hB, 1'b0);
    readOne(1'b1, 8'h05, 1'b1, "pre_reset_rd", 4'hA);
    @(negedge clk);
    #2;
    doReset(1'b1);
    for (int i = 0; i < 100; i++)
      applyStimulus(1'b1, 8'($urandom), 8'($urandom), 1'b0, 1'b1, 4'hF, 1'b1);
    doReset(1'b1);
    runSweep();
    readOne(1'b1, 8'h06, 1'b1, "a06_after_reset", 4'd0);
    for (int i = 0; i < 256; i++) applyStimulus(1'b1, 8'(i), 8'h00, 1'b1, 1'b0, 4'd0, 1'b1);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
